// File: rtl/cmu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmu_pkg
//  Description : Shared definitions for the cached memory unit: operation
//                encodings, controller state type and field-width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmu_pkg;

  // Request operation encodings
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_RD    = 2'b01;
  localparam logic [1:0] OP_WR    = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WBACK  = 3'd2,
    S_FILL   = 3'd3,
    S_PTR    = 3'd4,
    S_RESP   = 3'd5,
    S_FLUSH  = 3'd6
  } cmu_state_t;

  // Address field widths as functions of the geometry
  function automatic int cmu_off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int cmu_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int cmu_tag_w(input int addr_w, input int lines, input int words);
    return addr_w - $clog2(lines) - $clog2(words);
  endfunction

  // Zero-width fields are carried as a single constant-zero bit
  function automatic int cmu_vec_w(input int w);
    return (w < 1) ? 1 : w;
  endfunction

  // Field widths of the default geometry (8-bit address, 16 lines, 2 words)
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LINES  = 16;
  localparam int DEF_WORDS  = 2;
  localparam int OFF_W      = cmu_off_w(DEF_WORDS);
  localparam int IDX_W      = cmu_idx_w(DEF_LINES);
  localparam int TAG_W      = cmu_tag_w(DEF_ADDR_W, DEF_LINES, DEF_WORDS);

endpackage
`default_nettype wire

// File: rtl/cmu_backing_ram.sv
`default_nettype none
// ============================================================================
//  Module      : cmu_backing_ram
//  Description : Variable-latency backing store. An access is held on the
//                interface (start high) for RAM_LAT cycles; rdy pulses on the
//                last of them, which is also the only cycle a write commits.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmu_backing_ram #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdy
);

  localparam int              CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RAM_LAT - 1);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Count cycles of the current access window; rdy marks its final cycle
  always_comb begin
    rdy   = start && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = rdy ? '0 : cnt_q + 1'b1;
    end
  end

  // Window counter; an abandoned access restarts from zero
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Storage array; writes land only at the end of a completed window
  always_ff @(posedge clk) begin
    if (rdy && rw) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/cached_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cached_mem_unit
//  Description : Direct-mapped, write-back, write-allocate cache with
//                multi-word lines, indirect addressing and whole-cache flush,
//                in front of a variable-latency backing RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module cached_mem_unit
  import cmu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int LINES   = 16,
  parameter int WORDS   = 2,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic              indirect,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              hit
);

  localparam int OFF_B  = cmu_off_w(WORDS);
  localparam int IDX_B  = cmu_idx_w(LINES);
  localparam int TAG_B  = cmu_tag_w(ADDR_W, LINES, WORDS);
  localparam int OFF_V  = cmu_vec_w(OFF_B);
  localparam int TAG_V  = cmu_vec_w(TAG_B);
  localparam int NSLOT  = LINES * WORDS;
  localparam int SLOT_W = $clog2(NSLOT);
  localparam logic [OFF_V-1:0] LAST_WORD = OFF_V'(WORDS - 1);
  localparam logic [IDX_B-1:0] LAST_LINE = IDX_B'(LINES - 1);

  // Flat data-array slot of word w in line i
  function automatic logic [SLOT_W-1:0] slot_of(input logic [IDX_B-1:0] i, input logic [OFF_V-1:0] w);
    return SLOT_W'(int'(i) * WORDS + int'(w));
  endfunction

  // RAM address {tag, index, word}; fields never carry into each other
  function automatic logic [ADDR_W-1:0] ram_addr_of(input logic [TAG_V-1:0] t, input logic [IDX_B-1:0] i,
                                                    input logic [OFF_V-1:0] w);
    return (ADDR_W'(t) << (IDX_B + OFF_B)) | (ADDR_W'(i) << OFF_B) | ADDR_W'(w);
  endfunction

  cmu_state_t        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ind_q, ind_d;
  logic              first_q, first_d;
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [OFF_V-1:0]  wcnt_q, wcnt_d;
  logic [IDX_B-1:0]  line_q, line_d;
  logic              fwb_q, fwb_d;
  logic              ptr_q, ptr_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;

  logic [TAG_V-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [NSLOT];

  logic [OFF_V-1:0]  cur_off;
  logic [IDX_B-1:0]  cur_idx;
  logic [TAG_V-1:0]  cur_tag;
  logic [SLOT_W-1:0] cur_slot;
  logic              lkp_hit;

  logic              ram_start, ram_rw, ram_rdy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              data_we, tag_we;
  logic [SLOT_W-1:0] data_slot;
  logic [DATA_W-1:0] data_wval;

  assign cur_off  = OFF_V'(addr_q & ADDR_W'(WORDS - 1));
  assign cur_idx  = IDX_B'(addr_q >> OFF_B);
  assign cur_tag  = TAG_V'(addr_q >> (OFF_B + IDX_B));
  assign cur_slot = slot_of(cur_idx, cur_off);
  assign lkp_hit  = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);

  cmu_backing_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RAM_LAT(RAM_LAT)
  ) u_ram (
    .clk  (clk),
    .clr_n(clr_n),
    .start(ram_start),
    .rw   (ram_rw),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata),
    .rdy  (ram_rdy)
  );

  // Controller next-state, array write strobes and RAM sequencing
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ind_d     = ind_q;
    first_d   = first_q;
    hit_d     = hit_q;
    rdata_d   = rdata_q;
    wcnt_d    = wcnt_q;
    line_d    = line_q;
    fwb_d     = fwb_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    ram_start = 1'b0;
    ram_rw    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    data_we   = 1'b0;
    data_slot = cur_slot;
    data_wval = wdata_q;
    tag_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && (op != OP_NOP)) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          ind_d   = indirect;
          first_d = 1'b1;
          hit_d   = 1'b0;
          wcnt_d  = '0;
          line_d  = '0;
          fwb_d   = 1'b0;
          ptr_d   = 1'b0;
          state_d = (op == OP_FLUSH) ? S_FLUSH : S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        wcnt_d = '0;
        // Only the first lookup of the data access is reported as hit/miss
        if (!ind_q && first_q) begin
          hit_d   = lkp_hit;
          first_d = 1'b0;
        end
        if (lkp_hit) begin
          if (ind_q) begin
            state_d = S_PTR;
          end else begin
            if (op_q == OP_WR) begin
              data_we          = 1'b1;
              dirty_d[cur_idx] = 1'b1;
              rdata_d          = wdata_q;
            end else begin
              rdata_d = data_mem[cur_slot];
            end
            state_d = S_RESP;
          end
        end else if (valid_q[cur_idx] && dirty_q[cur_idx]) begin
          state_d = S_WBACK;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WBACK: begin
        ram_start = 1'b1;
        ram_rw    = 1'b1;
        ram_addr  = ram_addr_of(tag_mem[cur_idx], cur_idx, wcnt_q);
        ram_wdata = data_mem[slot_of(cur_idx, wcnt_q)];
        if (ram_rdy) begin
          if (wcnt_q == LAST_WORD) begin
            wcnt_d           = '0;
            dirty_d[cur_idx] = 1'b0;
            state_d          = S_FILL;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      S_FILL: begin
        ram_start = 1'b1;
        ram_addr  = ram_addr_of(cur_tag, cur_idx, wcnt_q);
        if (ram_rdy) begin
          data_we   = 1'b1;
          data_slot = slot_of(cur_idx, wcnt_q);
          data_wval = ram_rdata;
          if (wcnt_q == LAST_WORD) begin
            tag_we           = 1'b1;
            valid_d[cur_idx] = 1'b1;
            dirty_d[cur_idx] = 1'b0;
            wcnt_d           = '0;
            state_d          = S_LOOKUP;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      S_PTR: begin
        // The pointer word is given a settling cycle before it re-drives the
        // index/tag decode of the effective address
        if (!ptr_q) begin
          ptr_d = 1'b1;
        end else begin
          addr_d  = ADDR_W'(data_mem[cur_slot]);
          ind_d   = 1'b0;
          ptr_d   = 1'b0;
          state_d = S_LOOKUP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_FLUSH: begin
        if (!fwb_q) begin
          if (dirty_q[line_q]) begin
            fwb_d  = 1'b1;
            wcnt_d = '0;
          end else if (line_q == LAST_LINE) begin
            rdata_d = '0;
            hit_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            line_d = line_q + 1'b1;
          end
        end else begin
          ram_start = 1'b1;
          ram_rw    = 1'b1;
          ram_addr  = ram_addr_of(tag_mem[line_q], line_q, wcnt_q);
          ram_wdata = data_mem[slot_of(line_q, wcnt_q)];
          if (ram_rdy) begin
            if (wcnt_q == LAST_WORD) begin
              wcnt_d          = '0;
              dirty_d[line_q] = 1'b0;
              fwb_d           = 1'b0;
              if (line_q == LAST_LINE) begin
                rdata_d = '0;
                hit_d   = 1'b0;
                state_d = S_RESP;
              end else begin
                line_d = line_q + 1'b1;
              end
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller and line-status registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      ind_q   <= 1'b0;
      first_q <= 1'b0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
      wcnt_q  <= '0;
      line_q  <= '0;
      fwb_q   <= 1'b0;
      ptr_q   <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ind_q   <= ind_d;
      first_q <= first_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
      wcnt_q  <= wcnt_d;
      line_q  <= line_d;
      fwb_q   <= fwb_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays keep their contents across reset
  always_ff @(posedge clk) begin
    if (data_we) data_mem[data_slot] <= data_wval;
    if (tag_we)  tag_mem[cur_idx]    <= cur_tag;
  end

  assign rdata = rdata_q;
  assign done  = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);
  assign hit   = hit_q && (state_q == S_RESP);

endmodule
`default_nettype wire

// File: tb/tb_cached_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cached_mem_unit
//  Description : Directed self-checking bench for cached_mem_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cached_mem_unit;
  import cmu_pkg::*;

  logic        clk      = 1'b0;
  logic        clr_n    = 1'b1;
  logic        req      = 1'b0;
  logic [1:0]  op       = 2'b00;
  logic        indirect = 1'b0;
  logic [7:0]  addr     = 8'h00;
  logic [15:0] wdata    = 16'h0000;
  logic [15:0] rdata;
  logic        done, busy, hit;

  int          total  = 0;
  int          passed = 0;
  int          fails  = 0;
  int          lat;
  logic [15:0] rd;
  logic        h;
  int          dones, first_done;
  logic        busy8, busy9, done10;

  cached_mem_unit u_dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .req     (req),
    .op      (op),
    .indirect(indirect),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .done    (done),
    .busy    (busy),
    .hit     (hit)
  );

  always #5 clk = ~clk;

  // Background RAM content for every address not explicitly preloaded
  function automatic logic [15:0] pat(input logic [7:0] a);
    return {8'hA5, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request; lat is the cycle (accept edge = cycle 0) in which done is seen
  task automatic run(input logic [1:0] o, input logic ind, input logic [7:0] a, input logic [15:0] wd,
                     output int l, output logic [15:0] r, output logic hh);
    @(negedge clk);
    req = 1'b1; op = o; indirect = ind; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; op = OP_NOP; indirect = 1'b0;
    l = 1;
    while (!done && l < 200) begin
      @(posedge clk);
      #1;
      l++;
    end
    r  = rdata;
    hh = hit;
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) u_dut.u_ram.mem[i] = pat(8'(i));
    u_dut.u_ram.mem[8'h12] = 16'hBEEF;
    u_dut.u_ram.mem[8'h05] = 16'h0040;
    u_dut.u_ram.mem[8'h40] = 16'hCAFE;

    #2 clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_hit",   32'(hit),   32'h0);
    @(negedge clk) clr_n = 1'b1;

    // Cold read miss, clean victim
    run(OP_RD, 1'b0, 8'h12, 16'h0, lat, rd, h);
    chk("rd12_miss_lat", 32'(lat), 32'd7);
    chk("rd12_miss_data", 32'(rd), 32'hBEEF);
    chk("rd12_miss_hit", 32'(h), 32'h0);

    // Same address again hits
    run(OP_RD, 1'b0, 8'h12, 16'h0, lat, rd, h);
    chk("rd12_hit_lat", 32'(lat), 32'd2);
    chk("rd12_hit_data", 32'(rd), 32'hBEEF);
    chk("rd12_hit_hit", 32'(h), 32'h1);

    // Write hit dirties the line
    run(OP_WR, 1'b0, 8'h12, 16'h1234, lat, rd, h);
    chk("wr12_lat", 32'(lat), 32'd2);
    chk("wr12_data", 32'(rd), 32'h1234);
    chk("wr12_hit", 32'(h), 32'h1);

    // Conflicting tag forces writeback then fill
    run(OP_RD, 1'b0, 8'h52, 16'h0, lat, rd, h);
    chk("rd52_lat", 32'(lat), 32'd11);
    chk("rd52_data", 32'(rd), 32'(pat(8'h52)));
    chk("rd52_hit", 32'(h), 32'h0);
    chk("wb_ram12", 32'(u_dut.u_ram.mem[8'h12]), 32'h1234);
    chk("wb_ram13", 32'(u_dut.u_ram.mem[8'h13]), 32'(pat(8'h13)));

    // Indirect read: pointer miss, then data miss
    run(OP_RD, 1'b1, 8'h05, 16'h0, lat, rd, h);
    chk("ind_lat", 32'(lat), 32'd15);
    chk("ind_data", 32'(rd), 32'hCAFE);
    chk("ind_hit", 32'(h), 32'h0);
    chk("ind_ptr_kept", 32'(u_dut.u_ram.mem[8'h05]), 32'h0040);

    // Two dirty lines, then flush
    run(OP_WR, 1'b0, 8'h20, 16'hAAAA, lat, rd, h);
    chk("wr20_lat", 32'(lat), 32'd7);
    chk("wr20_hit", 32'(h), 32'h0);
    run(OP_WR, 1'b0, 8'h31, 16'h5555, lat, rd, h);
    chk("wr31_lat", 32'(lat), 32'd7);
    chk("pre_flush_ram20", 32'(u_dut.u_ram.mem[8'h20]), 32'(pat(8'h20)));
    run(OP_FLUSH, 1'b0, 8'h00, 16'h0, lat, rd, h);
    chk("flush_lat", 32'(lat), 32'd25);
    chk("flush_rdata", 32'(rd), 32'h0);
    chk("flush_hit", 32'(h), 32'h0);
    chk("flush_ram20", 32'(u_dut.u_ram.mem[8'h20]), 32'hAAAA);
    chk("flush_ram31", 32'(u_dut.u_ram.mem[8'h31]), 32'h5555);
    run(OP_RD, 1'b0, 8'h20, 16'h0, lat, rd, h);
    chk("rd20_lat", 32'(lat), 32'd2);
    chk("rd20_data", 32'(rd), 32'hAAAA);
    chk("rd20_hit", 32'(h), 32'h1);

    // req held high through a miss: one done, re-accept right after it
    dones = 0; first_done = 0; busy8 = 1'b0; busy9 = 1'b0; done10 = 1'b0;
    @(negedge clk);
    req = 1'b1; op = OP_RD; indirect = 1'b0; addr = 8'h60;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (c <= 9 && done) begin
        dones++;
        if (first_done == 0) first_done = c;
      end
      if (c == 8)  busy8 = busy;
      if (c == 9) begin
        busy9 = busy;
        req   = 1'b0;
        op    = OP_NOP;
      end
      if (c == 10) done10 = done;
      @(posedge clk);
    end
    chk("hold_done_count", 32'(dones), 32'd1);
    chk("hold_done_cycle", 32'(first_done), 32'd7);
    chk("hold_busy_after_done", 32'(busy8), 32'h0);
    chk("hold_reaccept", 32'(busy9), 32'h1);
    chk("hold_second_done", 32'(done10), 32'h1);

    // Reset during a writeback word
    run(OP_WR, 1'b0, 8'h12, 16'h7777, lat, rd, h);
    chk("wr12b_lat", 32'(lat), 32'd7);
    @(negedge clk);
    req = 1'b1; op = OP_RD; addr = 8'h52;
    @(posedge clk);
    #1;
    req = 1'b0; op = OP_NOP;
    @(posedge clk);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_mid_ram12", 32'(u_dut.u_ram.mem[8'h12]), 32'h1234);
    chk("rst_mid_ram13", 32'(u_dut.u_ram.mem[8'h13]), 32'(pat(8'h13)));
    @(negedge clk) clr_n = 1'b1;
    run(OP_RD, 1'b0, 8'h12, 16'h0, lat, rd, h);
    chk("post_rst_lat", 32'(lat), 32'd7);
    chk("post_rst_data", 32'(rd), 32'h1234);
    chk("post_rst_hit", 32'(h), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
